// File: rtl/rock_sequencer.sv
// Rocking session scheduler: paces path-finder evaluations and turns its
// up/down decisions into saturating frequency and amplitude setpoints.
module rock_sequencer #(
    parameter int FW           = 8,
    parameter int AW           = 8,
    parameter int FREQ_INIT    = 64,
    parameter int AMP_INIT     = 128,
    parameter int FSTEP        = 4,
    parameter int ASTEP        = 8,
    parameter int FMIN         = 16,
    parameter int FMAX         = 240,
    parameter int AMIN         = 16,
    parameter int SETTLE_TICKS = 10,
    parameter int ERR_LIMIT    = 3,
    parameter int CALM_EVALS   = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          start,
    input  logic          stop,
    input  logic          stress_in,
    input  logic          fplus,
    input  logic          fmin,
    input  logic          amin,
    input  logic          pf_error,
    output logic          stress_s,
    output logic          pf_step,
    output logic          pf_reset,
    output logic [FW-1:0] freq,
    output logic [AW-1:0] ampl,
    output logic          motor_en,
    output logic          alarm,
    output logic          done,
    output logic [2:0]    state
);

    localparam int SW = $clog2(SETTLE_TICKS + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam int CW = $clog2(CALM_EVALS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_EVAL   = 3'd2,
        S_APPLY  = 3'd3,
        S_DONE   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t        cur, nxt;
    logic [FW-1:0] freq_q, freq_d, freq_new;
    logic [AW-1:0] ampl_q, ampl_d, ampl_new;
    logic [SW-1:0] settle_q, settle_d;
    logic [EW-1:0] err_q, err_d, err_new;
    logic [CW-1:0] calm_q, calm_d, calm_new;
    logic [4:0]    ev_q, ev_d;
    logic          alarm_q, alarm_d;
    logic          done_q, done_d;
    logic          sync1, sync2;
    logic [FW:0]   f_sum, f_dif;
    logic [AW:0]   a_dif;
    logic          e_up, e_dn, e_am, e_err, e_stress;

    assign {e_up, e_dn, e_am, e_err, e_stress} = ev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= stress_in;
            sync2 <= sync1;
        end
    end

    // Widened by one bit so a step past either bound is visible, not wrapped.
    always_comb begin
        f_sum    = {1'b0, freq_q} + (FW+1)'(FSTEP);
        f_dif    = {1'b0, freq_q} - (FW+1)'(FSTEP);
        a_dif    = {1'b0, ampl_q} - (AW+1)'(ASTEP);
        freq_new = freq_q;
        ampl_new = ampl_q;
        if (e_up && !e_dn) begin
            if (f_sum > (FW+1)'(FMAX)) freq_new = FW'(FMAX);
            else                       freq_new = f_sum[FW-1:0];
        end else if (e_dn && !e_up) begin
            if (f_dif[FW] || f_dif < (FW+1)'(FMIN)) freq_new = FW'(FMIN);
            else                                    freq_new = f_dif[FW-1:0];
        end
        if (e_am) begin
            if (a_dif[AW] || a_dif < (AW+1)'(AMIN)) ampl_new = AW'(AMIN);
            else                                    ampl_new = a_dif[AW-1:0];
        end
        err_new  = e_err    ? err_q + EW'(1) : '0;
        calm_new = e_stress ? '0 : calm_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= S_IDLE;
            freq_q   <= FW'(FREQ_INIT);
            ampl_q   <= AW'(AMP_INIT);
            settle_q <= '0;
            err_q    <= '0;
            calm_q   <= '0;
            ev_q     <= '0;
            alarm_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cur      <= nxt;
            freq_q   <= freq_d;
            ampl_q   <= ampl_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            calm_q   <= calm_d;
            ev_q     <= ev_d;
            alarm_q  <= alarm_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        nxt      = cur;
        freq_d   = freq_q;
        ampl_d   = ampl_q;
        settle_d = settle_q;
        err_d    = err_q;
        calm_d   = calm_q;
        ev_d     = ev_q;
        alarm_d  = alarm_q;
        done_d   = done_q;
        if (cur != S_IDLE && stop) begin
            nxt     = S_IDLE;
            alarm_d = 1'b0;
            done_d  = 1'b0;
        end else begin
            unique case (cur)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        nxt      = S_SETTLE;
                        freq_d   = FW'(FREQ_INIT);
                        ampl_d   = AW'(AMP_INIT);
                        settle_d = SW'(SETTLE_TICKS);
                        err_d    = '0;
                        calm_d   = '0;
                        done_d   = 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == '0)
                        nxt = S_EVAL;
                    else if (tick)
                        settle_d = settle_q - SW'(1);
                end
                S_EVAL: begin
                    ev_d = {fplus, fmin, amin, pf_error, sync2};
                    nxt  = S_APPLY;
                end
                S_APPLY: begin
                    freq_d = freq_new;
                    ampl_d = ampl_new;
                    err_d  = err_new;
                    calm_d = calm_new;
                    if (err_new >= EW'(ERR_LIMIT)) begin
                        nxt     = S_HALT;
                        alarm_d = 1'b1;
                    end else if (calm_new >= CW'(CALM_EVALS)) begin
                        nxt    = S_DONE;
                        done_d = 1'b1;
                    end else begin
                        nxt = S_SETTLE;
                        // A saturated no-op leaves the motor as-is: re-evaluate soon.
                        if (freq_new != freq_q || ampl_new != ampl_q)
                            settle_d = SW'(SETTLE_TICKS);
                        else
                            settle_d = SW'(1);
                    end
                end
                S_HALT: nxt = S_HALT;
                default: nxt = S_IDLE;
            endcase
        end
    end

    assign motor_en = (cur == S_SETTLE) || (cur == S_EVAL) || (cur == S_APPLY);
    assign pf_reset = !motor_en;
    assign pf_step  = (cur == S_EVAL);
    assign stress_s = sync2;
    assign freq     = freq_q;
    assign ampl     = ampl_q;
    assign alarm    = alarm_q;
    assign done     = done_q;
    assign state    = cur;

endmodule

// File: tb/tb_rock_sequencer.sv
// Directed bench for rock_sequencer with a per-cycle behavioural model
// and literal spot checks on the key setpoint and state values.
module tb_rock_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       stress_in = 1'b0;
    logic       fplus = 1'b0;
    logic       fmin = 1'b0;
    logic       amin = 1'b0;
    logic       pf_error = 1'b0;
    logic       stress_s, pf_step, pf_reset, motor_en, alarm, done;
    logic [7:0] freq, ampl;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    rock_sequencer dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
        .stress_in(stress_in), .fplus(fplus), .fmin(fmin), .amin(amin),
        .pf_error(pf_error), .stress_s(stress_s), .pf_step(pf_step),
        .pf_reset(pf_reset), .freq(freq), .ampl(ampl), .motor_en(motor_en),
        .alarm(alarm), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    // Timebase: one tick every third cycle, running through every state.
    initial begin
        int tc;
        tc = 0;
        forever begin
            @(posedge clk);
            #2;
            tick = (tc % 3 == 0);
            tc++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: session rules in plain integer arithmetic.
    int m_st, m_f, m_a, m_wait, m_err, m_calm;
    bit m_s1, m_s2, m_alarm, m_done;
    bit l_up, l_dn, l_am, l_er, l_s;

    always @(posedge clk or posedge reset) begin
        int nf, na, ne, nc;
        if (reset) begin
            m_st <= 0; m_f <= 64; m_a <= 128; m_wait <= 0;
            m_err <= 0; m_calm <= 0; m_s1 <= 0; m_s2 <= 0;
            m_alarm <= 0; m_done <= 0;
            l_up <= 0; l_dn <= 0; l_am <= 0; l_er <= 0; l_s <= 0;
        end else begin
            m_s1 <= stress_in;
            m_s2 <= m_s1;
            if (m_st != 0 && stop) begin
                m_st <= 0; m_alarm <= 0; m_done <= 0;
            end else if ((m_st == 0 || m_st == 4) && start) begin
                m_st <= 1; m_f <= 64; m_a <= 128; m_wait <= 10;
                m_err <= 0; m_calm <= 0; m_done <= 0;
            end else if (m_st == 1) begin
                if (m_wait == 0) m_st <= 2;
                else if (tick) m_wait <= m_wait - 1;
            end else if (m_st == 2) begin
                l_up <= fplus; l_dn <= fmin; l_am <= amin;
                l_er <= pf_error; l_s <= m_s2;
                m_st <= 3;
            end else if (m_st == 3) begin
                nf = m_f;
                if (l_up && !l_dn) nf = (m_f + 4 > 240) ? 240 : m_f + 4;
                else if (l_dn && !l_up) nf = (m_f - 4 < 16) ? 16 : m_f - 4;
                na = l_am ? ((m_a - 8 < 16) ? 16 : m_a - 8) : m_a;
                ne = l_er ? m_err + 1 : 0;
                nc = l_s ? 0 : m_calm + 1;
                m_f <= nf; m_a <= na; m_err <= ne; m_calm <= nc;
                if (ne >= 3) begin
                    m_st <= 5; m_alarm <= 1;
                end else if (nc >= 5) begin
                    m_st <= 4; m_done <= 1;
                end else begin
                    m_st <= 1;
                    m_wait <= (nf != m_f || na != m_a) ? 10 : 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("state", state, m_st);
        chk("freq", freq, m_f);
        chk("ampl", ampl, m_a);
        chk("motor_en", motor_en, (m_st >= 1 && m_st <= 3));
        chk("pf_reset", pf_reset, !(m_st >= 1 && m_st <= 3));
        chk("pf_step", pf_step, m_st == 2);
        chk("alarm", alarm, m_alarm);
        chk("done", done, m_done);
        chk("stress_s", stress_s, m_s2);
    end

    // Returns at posedge+2 just after the APPLY of each evaluation.
    task automatic wait_eval(input int n);
        for (int k = 0; k < n; k++) begin
            int cyc;
            cyc = 0;
            while (pf_step !== 1'b1 && cyc < 400) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 400) begin
                n_cmp++;
                n_bad++;
                $display("FAIL eval_timeout: got no pf_step expected one within 400 cycles");
                return;
            end
            @(posedge clk); #2;
            @(posedge clk); #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk); #2;
        stop = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_state", state, 0);
        chk("rst_freq", freq, 64);
        chk("rst_ampl", ampl, 128);
        chk("rst_pf_reset", pf_reset, 1);
        chk("rst_motor_en", motor_en, 0);
        reset = 1'b0;
        @(posedge clk); #2;

        // First window and frequency ramp to the ceiling.
        stress_in = 1; fplus = 1;
        pulse_start();
        wait_eval(1);
        chk("lit_freq68", freq, 68);
        chk("lit_settle_state", state, 1);
        wait_eval(43);
        chk("lit_freq240", freq, 240);
        wait_eval(1);
        chk("lit_freq240_hold", freq, 240);

        // Conflicting frequency requests, amplitude down to floor.
        fmin = 1; amin = 1;
        wait_eval(1);
        chk("lit_freq_both", freq, 240);
        chk("lit_ampl120", ampl, 120);
        wait_eval(13);
        chk("lit_ampl16", ampl, 16);
        wait_eval(1);
        chk("lit_ampl16_hold", ampl, 16);
        pulse_stop();
        chk("lit_stop_idle", state, 0);

        // Error escalation to HALT.
        fplus = 0; fmin = 0; amin = 0; pf_error = 1;
        pulse_start();
        wait_eval(3);
        chk("lit_halt_state", state, 5);
        chk("lit_halt_alarm", alarm, 1);
        chk("lit_halt_motor", motor_en, 0);
        repeat (5) @(posedge clk);
        #2;
        chk("lit_halt_sticky", state, 5);
        pulse_stop();
        chk("lit_halt_stop", state, 0);
        chk("lit_halt_alarm_clr", alarm, 0);

        // Error run broken in the second evaluation.
        pulse_start();
        wait_eval(1);
        pf_error = 0;
        wait_eval(1);
        pf_error = 1;
        wait_eval(2);
        chk("lit_no_halt", state, 1);
        chk("lit_no_alarm", alarm, 0);
        pulse_stop();

        // Calm session to DONE.
        pf_error = 0; stress_in = 0;
        pulse_start();
        wait_eval(5);
        chk("lit_done_state", state, 4);
        chk("lit_done_flag", done, 1);
        chk("lit_done_motor", motor_en, 0);

        // Restart from DONE; stress pulse in the 4th evaluation.
        pulse_start();
        chk("lit_restart", state, 1);
        chk("lit_restart_done", done, 0);
        wait_eval(3);
        stress_in = 1;
        wait_eval(1);
        stress_in = 0;
        wait_eval(4);
        chk("lit_calm_reset", state, 1);
        wait_eval(1);
        chk("lit_done_late", state, 4);
        pulse_stop();
        chk("lit_done_clr", done, 0);

        // Reset mid-SETTLE at freq 80.
        stress_in = 1; fplus = 1;
        pulse_start();
        wait_eval(4);
        chk("lit_freq80", freq, 80);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("lit_arst_freq", freq, 64);
        chk("lit_arst_state", state, 0);
        chk("lit_arst_motor", motor_en, 0);
        chk("lit_arst_pfr", pf_reset, 1);
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #2;

        // stop during APPLY suppresses the setpoint update.
        pulse_start();
        begin
            int cyc;
            cyc = 0;
            while (pf_step !== 1'b1 && cyc < 400) begin
                @(negedge clk);
                cyc++;
            end
            chk("lit_eval_seen", pf_step, 1);
        end
        @(posedge clk); #2;
        chk("lit_in_apply", state, 3);
        pulse_stop();
        chk("lit_apply_stop", state, 0);
        chk("lit_apply_freq", freq, 64);
        repeat (3) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
